// File: rtl/plru_pkg.sv
// Shared types and tree-PLRU helpers for plru_table.
// Helpers work on maximum-width vectors so any Way up to 64 can use them.
package plru_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int unsigned MaxWaySel = 7;
    localparam int unsigned MaxStatW  = (1 << MaxWaySel) - 1;

    typedef logic [MaxStatW-1:0]  tree_t;
    typedef logic [MaxWaySel-1:0] way_t;

    // Children of node n are 2n+1 (way bit 0) and 2n+2 (way bit 1).
    function automatic tree_t tree_update(input tree_t tree, input way_t way,
                                          input int unsigned levels);
        tree_t       t;
        int unsigned node;
        logic        b;
        t    = tree;
        node = 0;
        for (int unsigned k = 0; k < MaxWaySel; k++) begin
            if (k < levels) begin
                b       = way[levels - 1 - k];
                t[node] = ~b;
                node    = 2 * node + 1 + int'(b);
            end
        end
        return t;
    endfunction

    function automatic way_t tree_victim(input tree_t tree, input int unsigned levels);
        way_t        w;
        int unsigned node;
        logic        b;
        w    = '0;
        node = 0;
        for (int unsigned k = 0; k < MaxWaySel; k++) begin
            if (k < levels) begin
                b    = tree[node];
                w    = {w[MaxWaySel-2:0], b};
                node = 2 * node + 1 + int'(b);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/lru.sv
// Combinational tree-PLRU for one set: optional update, then victim walk
// of the (possibly updated) tree.
module lru
    import plru_pkg::*;
#(
    parameter  int unsigned Way    = 8,
    localparam int unsigned WaySel = $clog2(Way)
) (
    input  logic [Way-2:0]    tree_i,
    input  logic              upd_en_i,
    input  logic [WaySel-1:0] upd_way_i,
    output logic [Way-2:0]    tree_o,
    output logic [WaySel-1:0] victim_o
);

    tree_t tree_full;
    tree_t upd_full;
    way_t  victim_full;
    logic  unused_hi;

    always_comb begin
        tree_full   = tree_t'(tree_i);
        upd_full    = upd_en_i ? tree_update(tree_full, way_t'(upd_way_i), WaySel) : tree_full;
        victim_full = tree_victim(upd_full, WaySel);
    end

    assign tree_o    = upd_full[Way-2:0];
    assign victim_o  = victim_full[WaySel-1:0];
    assign unused_hi = ^{upd_full[MaxStatW-1:Way-1], victim_full[MaxWaySel-1:WaySel]};

endmodule

// File: rtl/plru_table.sv
// Per-set tree-PLRU state table with victim lookup and a one-set-per-cycle flush sweep.
// Define PLRU_LOCK_EN to add the per-way lock mask and the vic_none output.
module plru_table
    import plru_pkg::*;
#(
    parameter  int unsigned Way      = 8,
    parameter  int unsigned Set      = 64,
    localparam int unsigned WaySel   = $clog2(Way),
    localparam int unsigned SetSel   = $clog2(Set),
    localparam int unsigned LruStatW = Way - 1
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              flush,
    output logic              busy,
    input  logic              acc_valid,
    input  logic [SetSel-1:0] acc_set,
    input  logic [WaySel-1:0] acc_way,
    input  logic              vic_req,
    input  logic [SetSel-1:0] vic_set,
`ifdef PLRU_LOCK_EN
    input  logic [Way-1:0]    lock,
    output logic              vic_none,
`endif
    output logic              vic_valid,
    output logic [WaySel-1:0] vic_way
);

    state_e              state_q, state_d;
    logic [SetSel-1:0]   cnt_q, cnt_d;
    logic [LruStatW-1:0] tree_q [Set];
    logic                vic_valid_q, vic_valid_d;
    logic [WaySel-1:0]   vic_way_q, vic_way_d;
`ifdef PLRU_LOCK_EN
    logic                vic_none_q, vic_none_d;
`endif

    logic                acc_fire, vic_fire, bypass;
    logic [LruStatW-1:0] acc_tree, vic_tree_unused;
    logic [WaySel-1:0]   acc_victim_unused, tree_victim, final_victim;
    logic                tree_we;
    logic [SetSel-1:0]   tree_wa;
    logic [LruStatW-1:0] tree_wd;

    assign busy     = (state_q == FLUSH);
    assign acc_fire = acc_valid && !busy;
    assign vic_fire = vic_req && !busy;
    assign bypass   = acc_fire && (acc_set == vic_set);

    lru #(.Way(Way)) u_acc (
        .tree_i   (tree_q[acc_set]),
        .upd_en_i (acc_fire),
        .upd_way_i(acc_way),
        .tree_o   (acc_tree),
        .victim_o (acc_victim_unused)
    );

    // Same-set access is applied before the walk so lookups see write-first data.
    lru #(.Way(Way)) u_vic (
        .tree_i   (tree_q[vic_set]),
        .upd_en_i (bypass),
        .upd_way_i(acc_way),
        .tree_o   (vic_tree_unused),
        .victim_o (tree_victim)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tree_we = 1'b0;
        tree_wa = acc_set;
        tree_wd = acc_tree;
        case (state_q)
            IDLE: begin
                tree_we = acc_fire;
                if (flush) state_d = FLUSH;
            end
            FLUSH: begin
                tree_we = 1'b1;
                tree_wa = cnt_q;
                tree_wd = '0;
                cnt_d   = cnt_q + SetSel'(1);
                if (cnt_q == SetSel'(Set - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        final_victim = tree_victim;
        vic_valid_d  = vic_fire;
        vic_way_d    = vic_way_q;
`ifdef PLRU_LOCK_EN
        vic_none_d   = vic_none_q;
        if (lock[tree_victim]) begin
            final_victim = '0;
            for (int i = int'(Way) - 1; i >= 0; i--) begin
                if (!lock[i]) final_victim = WaySel'(i);
            end
        end
        if (vic_fire) vic_none_d = &lock;
`endif
        if (vic_fire) vic_way_d = final_victim;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vic_valid_q <= 1'b0;
            vic_way_q   <= '0;
`ifdef PLRU_LOCK_EN
            vic_none_q  <= 1'b0;
`endif
            // NOTE: the tree array is reset on purpose: reset must leave every set cleared.
            for (int s = 0; s < int'(Set); s++) tree_q[s] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vic_valid_q <= vic_valid_d;
            vic_way_q   <= vic_way_d;
`ifdef PLRU_LOCK_EN
            vic_none_q  <= vic_none_d;
`endif
            if (tree_we) tree_q[tree_wa] <= tree_wd;
        end
    end

    assign vic_valid = vic_valid_q;
    assign vic_way   = vic_way_q;
`ifdef PLRU_LOCK_EN
    assign vic_none  = vic_none_q;
`endif

endmodule

// File: tb/tb_plru_table.sv
// Self-checking bench for plru_table (Way=8, Set=4) against a recency-based PLRU model.
module tb_plru_table;

    localparam int Way = 8;
    localparam int Set = 4;

    logic       clk = 1'b0;
    logic       reset_;
    logic       flush;
    logic       busy;
    logic       acc_valid;
    logic [1:0] acc_set;
    logic [2:0] acc_way;
    logic       vic_req;
    logic [1:0] vic_set;
    logic       vic_valid;
    logic [2:0] vic_way;
`ifdef PLRU_LOCK_EN
    logic [7:0] lock;
    logic       vic_none;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: last-access timestamp per way (0 = never touched since clear).
    int unsigned ts [Set][Way];
    int unsigned now_t;

    always #5 clk = ~clk;

    plru_table #(.Way(Way), .Set(Set)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .flush    (flush),
        .busy     (busy),
        .acc_valid(acc_valid),
        .acc_set  (acc_set),
        .acc_way  (acc_way),
        .vic_req  (vic_req),
        .vic_set  (vic_set),
`ifdef PLRU_LOCK_EN
        .lock     (lock),
        .vic_none (vic_none),
`endif
        .vic_valid(vic_valid),
        .vic_way  (vic_way)
    );

    function automatic void model_clear();
        for (int s = 0; s < Set; s++)
            for (int w = 0; w < Way; w++) ts[s][w] = 0;
        now_t = 0;
    endfunction

    // Descend into the half whose most recent access is older; untouched halves tie to the left.
    function automatic int model_victim(input int s);
        int          lo, n, half;
        int unsigned lmax, rmax;
        lo = 0;
        n  = Way;
        while (n > 1) begin
            half = n / 2;
            lmax = 0;
            rmax = 0;
            for (int i = 0; i < half; i++) begin
                if (ts[s][lo + i] > lmax) lmax = ts[s][lo + i];
                if (ts[s][lo + half + i] > rmax) rmax = ts[s][lo + half + i];
            end
            if (rmax < lmax) lo = lo + half;
            n = half;
        end
        return lo;
    endfunction

    task automatic drive(input bit av, input int as, input int aw,
                         input bit vr, input int vs, output int exp_w);
        acc_valid = av;
        acc_set   = 2'(as);
        acc_way   = 3'(aw);
        vic_req   = vr;
        vic_set   = 2'(vs);
        if (av) begin
            now_t++;
            ts[as][aw] = now_t;
        end
        exp_w = vr ? model_victim(vs) : -1;
        @(posedge clk);
        #1;
        acc_valid = 1'b0;
        vic_req   = 1'b0;
    endtask

    task automatic test_reset();
        int e;
        reset_    = 1'b0;
        flush     = 1'b0;
        acc_valid = 1'b0;
        vic_req   = 1'b0;
        acc_set   = '0;
        acc_way   = '0;
        vic_set   = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (vic_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vic_valid: got %b expected 0", vic_valid); end
        n_checks++;
        if (vic_way !== 3'd0) begin n_fail++; $display("FAIL reset_vic_way: got %0d expected 0", vic_way); end
        @(negedge clk);
        reset_ = 1'b1;
        model_clear();
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 2, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_lookup_set2: got valid=%b way=%0d expected valid=1 way=0", vic_valid, vic_way);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (vic_valid !== 1'b0) begin n_fail++; $display("FAIL vic_valid_pulse: got %b expected 0", vic_valid); end
    endtask

    task automatic test_directed();
        int e;
        drive(1, 0, 0, 0, 0, e);
        n_checks++;
        if (dut.tree_q[0] !== 7'h0B) begin
            n_fail++;
            $display("FAIL tree0_after_way0: got %h expected 0b", dut.tree_q[0]);
        end
        drive(0, 0, 0, 1, 0, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'd4) begin
            n_fail++;
            $display("FAIL victim_set0: got valid=%b way=%0d expected valid=1 way=4", vic_valid, vic_way);
        end
        for (int w = 0; w < Way; w++) drive(1, 1, w, 0, 0, e);
        drive(0, 0, 0, 1, 1, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'd0) begin
            n_fail++;
            $display("FAIL victim_set1_sweep: got valid=%b way=%0d expected valid=1 way=0", vic_valid, vic_way);
        end
    endtask

    task automatic test_bypass();
        int e;
        drive(1, 3, 0, 1, 3, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'd4) begin
            n_fail++;
            $display("FAIL bypass_set3: got valid=%b way=%0d expected valid=1 way=4", vic_valid, vic_way);
        end
    endtask

    task automatic test_random();
        int  e, as, aw, vs;
        bit  av, vr;
        for (int i = 0; i < 300; i++) begin
            av = 1'($urandom_range(1));
            vr = 1'($urandom_range(1));
            as = int'($urandom_range(Set - 1));
            aw = int'($urandom_range(Way - 1));
            vs = ($urandom_range(3) == 0) ? as : int'($urandom_range(Set - 1));
            drive(av, as, aw, vr, vs, e);
            n_checks++;
            if (vr) begin
                if (vic_valid !== 1'b1 || vic_way !== 3'(e)) begin
                    n_fail++;
                    $display("FAIL random_victim[%0d]: got valid=%b way=%0d expected valid=1 way=%0d",
                             i, vic_valid, vic_way, e);
                end
            end else if (vic_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL random_idle[%0d]: got valid=%b expected 0", i, vic_valid);
            end
        end
    endtask

    task automatic test_flush();
        int e;
        drive(1, 0, 0, 0, 0, e);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        acc_valid = 1'b1;
        acc_set   = 2'd0;
        acc_way   = 3'd5;
        vic_req   = 1'b1;
        vic_set   = 2'd0;
        for (int i = 0; i < Set; i++) begin
            n_checks++;
            if (busy !== 1'b1 || vic_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_busy[%0d]: got busy=%b valid=%b expected busy=1 valid=0", i, busy, vic_valid);
            end
            flush = (i == 1);
            @(posedge clk);
            #1;
        end
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || vic_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_end: got busy=%b valid=%b expected busy=0 valid=0", busy, vic_valid);
        end
        acc_valid = 1'b0;
        vic_req   = 1'b0;
        model_clear();
        for (int s = 0; s < Set; s++) begin
            drive(0, 0, 0, 1, s, e);
            n_checks++;
            if (vic_valid !== 1'b1 || vic_way !== 3'd0) begin
                n_fail++;
                $display("FAIL flush_cleared_set%0d: got valid=%b way=%0d expected valid=1 way=0",
                         s, vic_valid, vic_way);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        int e;
        drive(1, 0, 0, 0, 0, e);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL midflush_busy: got %b expected 1", busy); end
        reset_ = 1'b0;
        #2;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midflush_reset_busy: got %b expected 0", busy); end
        #1;
        reset_ = 1'b1;
        model_clear();
        drive(0, 0, 0, 1, 0, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'(e)) begin
            n_fail++;
            $display("FAIL midflush_reset_set0: got valid=%b way=%0d expected valid=1 way=%0d", vic_valid, vic_way, e);
        end
        drive(1, 2, 6, 1, 2, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'(e)) begin
            n_fail++;
            $display("FAIL post_reset_bypass: got valid=%b way=%0d expected valid=1 way=%0d", vic_valid, vic_way, e);
        end
    endtask

`ifdef PLRU_LOCK_EN
    task automatic test_lock();
        int e;
        reset_ = 1'b0;
        #3;
        reset_ = 1'b1;
        model_clear();
        lock = 8'h01;
        drive(0, 0, 0, 1, 0, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'd1 || vic_none !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_way0: got way=%0d none=%b expected way=1 none=0", vic_way, vic_none);
        end
        lock = 8'hFF;
        drive(0, 0, 0, 1, 0, e);
        n_checks++;
        if (vic_valid !== 1'b1 || vic_way !== 3'd0 || vic_none !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_all: got way=%0d none=%b expected way=0 none=1", vic_way, vic_none);
        end
        lock = 8'h00;
    endtask
`endif

    initial begin
`ifdef PLRU_LOCK_EN
        lock = 8'h00;
`endif
        test_reset();
        test_directed();
        test_bypass();
        test_random();
        test_flush();
        test_reset_mid_flush();
`ifdef PLRU_LOCK_EN
        test_lock();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
